// File: rtl/aes_pkg.sv
// Shared AES definitions: forward S-box constant, lookup function and state/byte types.
package aes_pkg;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [127:0] aes_state_t;

  localparam int AES_LANES = 16;

  // Row r, column c holds SBOX(8'h{r,c}).
  localparam aes_byte_t AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic aes_byte_t aes_sbox_f(input aes_byte_t b);
    return AES_SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-lane AES forward S-box: pure combinational 8-bit table lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte_i,
  output logic [7:0] out_byte_o
);

  assign out_byte_o = aes_sbox_f(in_byte_i);

endmodule

// File: rtl/sub_bytes.sv
// AES SubBytes: 16 parallel S-box lanes feeding one registered output state.
module sub_bytes
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [127:0] msg,
  output logic         out_valid,
  output logic [127:0] msgout
);

  aes_state_t msgout_d;
  aes_state_t msgout_q;
  logic       out_valid_q;

  generate
    for (genvar gi = 0; gi < AES_LANES; gi++) begin : g_lane
      aes_sbox u_sbox (
        .in_byte_i  (msg[8*gi +: 8]),
        .out_byte_o (msgout_d[8*gi +: 8])
      );
    end
  endgenerate

  // The state register only loads on valid, so garbage on msg otherwise is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msgout_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        msgout_q <= msgout_d;
      end
    end
  end

  assign msgout    = msgout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sub_bytes.sv
// Directed bench for sub_bytes; exhaustive sweep uses an algebraic GF(2^8) S-box model.
module tb_sub_bytes;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [127:0] msg;
  logic         out_valid;
  logic [127:0] msgout;

  int n_vec;
  int n_err;

  sub_bytes dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .msg       (msg),
    .out_valid (out_valid),
    .msgout    (msgout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // Multiplicative inverse as a^254, then the FIPS-197 affine transform.
  function automatic logic [7:0] model_sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] m);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = model_sbox(m[8*i +: 8]);
    return o;
  endfunction

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] V2_IN  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] V2_OUT = 128'h63cab7040953d051cd60e0e7ba70e18c;
  localparam logic [127:0] V3_IN  = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] V3_OUT = 128'ha761ca9b97be8b45d8ad1a611fc97369;

  initial begin
    logic [127:0] m;
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    msg      = '0;

    // 1. Async reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk128("reset_msgout", msgout, 128'h0);
    chk1("reset_valid", out_valid, 1'b0);
    $display("reset: msgout=%h out_valid=%b", msgout, out_valid);
    step();
    rst = 1'b0;
    step();
    chk1("idle_valid", out_valid, 1'b0);

    // 2./3./4. Vectors back to back, then idle with garbage on msg
    in_valid = 1'b1;
    msg      = V2_IN;
    step();
    msg      = V3_IN;
    chk128("v2_msgout", msgout, V2_OUT);
    chk1("v2_valid", out_valid, 1'b1);
    $display("v2: in=%h out=%h", V2_IN, msgout);
    step();
    in_valid = 1'b0;
    msg      = 'x;
    chk128("v3_msgout", msgout, V3_OUT);
    chk1("v3_valid", out_valid, 1'b1);
    $display("v3: in=%h out=%h", V3_IN, msgout);
    step();
    msg = {$urandom, $urandom, $urandom, $urandom};
    chk1("idle_drop_valid", out_valid, 1'b0);
    chk128("idle_hold_msgout", msgout, V3_OUT);
    $display("idle: out_valid=%b msgout=%h", out_valid, msgout);
    step();
    chk128("idle_hold2_msgout", msgout, V3_OUT);

    // Spot checks against known table entries
    in_valid = 1'b1;
    msg      = 128'h0;
    msg[7:0]   = 8'h53;
    msg[15:8]  = 8'hff;
    msg[23:16] = 8'h01;
    msg[127:120] = 8'h89;
    step();
    chk128("spot_53", {120'h0, msgout[7:0]}, {120'h0, 8'hed});
    chk128("spot_ff", {120'h0, msgout[15:8]}, {120'h0, 8'h16});
    chk128("spot_01", {120'h0, msgout[23:16]}, {120'h0, 8'h7c});
    chk128("spot_00", {120'h0, msgout[31:24]}, {120'h0, 8'h63});
    chk128("spot_89", {120'h0, msgout[127:120]}, {120'h0, 8'ha7});
    $display("spot: out=%h", msgout);

    // 5. Exhaustive sweep: lane i carries (k+i) mod 256, so each lane sees every byte
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 16; i++) m[8*i +: 8] = 8'(k + i);
      msg = m;
      step();
      chk128("sweep", msgout, model_state(m));
      $display("sweep k=%0d: in=%h out=%h", k, m, msgout);
    end
    chk1("sweep_valid", out_valid, 1'b1);

    // 6. Reset mid-stream: input set, rst raised before the capturing edge
    msg = V2_IN;
    #2 rst = 1'b1;
    #1;
    chk128("midrst_msgout", msgout, 128'h0);
    chk1("midrst_valid", out_valid, 1'b0);
    step();
    chk128("midrst_edge_msgout", msgout, 128'h0);
    chk1("midrst_edge_valid", out_valid, 1'b0);
    $display("midreset: msgout=%h out_valid=%b", msgout, out_valid);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    chk1("post_rst_idle_valid", out_valid, 1'b0);
    in_valid = 1'b1;
    msg      = V3_IN;
    step();
    in_valid = 1'b0;
    chk128("post_rst_msgout", msgout, V3_OUT);
    chk1("post_rst_valid", out_valid, 1'b1);
    $display("post-reset: in=%h out=%h", V3_IN, msgout);
    step();
    chk1("post_rst_drop_valid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
